// File: rtl/demux4_pkg.sv
// Shared sizing constants for the 4-way registered demultiplexer.
package demux4_pkg;

  localparam int unsigned N_OUT = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register: loads a word, holds it until drained.
module demux_slot
  import demux4_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             drain,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Drain clears valid; a same-cycle load overrides it. Data is kept on drain.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && drain) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer with per-destination one-entry slots,
// valid/ready handshakes and a sticky input-protocol error flag.
// Optional per-destination delivery counters: define DEMUX4_CNT_EN.
module demux4_reg
  import demux4_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [3:0]       o_valid,
  input  logic [3:0]       o_ready,
  output logic             proto_err
`ifdef DEMUX4_CNT_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1,
  output logic [15:0]      cnt2,
  output logic [15:0]      cnt3
`endif
);

  logic [N_OUT-1:0] load;
  logic [N_OUT-1:0] valid;
  logic [WIDTH-1:0] slot_data [N_OUT];
  logic             accept;

  logic             stall_q, stall_d;
  logic [WIDTH-1:0] din_hold_q, din_hold_d;
  logic [SEL_W-1:0] sel_hold_q, sel_hold_d;
  logic             proto_err_q, proto_err_d;

  // Ready passes through when the selected slot drains in the same cycle.
  assign din_ready = !valid[sel] || o_ready[sel];
  assign accept    = din_valid && din_ready;

  // One-hot load strobe towards the selected slot.
  always_comb begin
    load      = '0;
    load[sel] = accept;
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load[k]),
      .load_data (din),
      .drain     (o_ready[k]),
      .data      (slot_data[k]),
      .valid     (valid[k])
    );
  end

  // A stalled offer must be held unchanged until it is taken.
  always_comb begin
    stall_d     = din_valid && !din_ready;
    din_hold_d  = din;
    sel_hold_d  = sel;
    proto_err_d = proto_err_q |
                  (stall_q && (!din_valid || (sel != sel_hold_q) || (din != din_hold_q)));
  end

  // Protocol monitor registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q     <= 1'b0;
      din_hold_q  <= '0;
      sel_hold_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      stall_q     <= stall_d;
      din_hold_q  <= din_hold_d;
      sel_hold_q  <= sel_hold_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign o0        = slot_data[0];
  assign o1        = slot_data[1];
  assign o2        = slot_data[2];
  assign o3        = slot_data[3];
  assign o_valid   = valid;
  assign proto_err = proto_err_q;

`ifdef DEMUX4_CNT_EN
  logic [CNT_W-1:0] cnt_q [N_OUT];
  logic [CNT_W-1:0] cnt_d [N_OUT];

  // Count deliveries per destination; wraps naturally at full scale.
  always_comb begin
    for (int k = 0; k < N_OUT; k++) begin
      cnt_d[k] = cnt_q[k] + CNT_W'(valid[k] && o_ready[k]);
    end
  end

  // Delivery counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_OUT; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];
`endif

endmodule

// File: tb/tb_demux4_reg.sv
// Self-checking bench for demux4_reg: transaction-level model plus directed vectors.
module tb_demux4_reg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [1:0] sel;
  logic [7:0] o0, o1, o2, o3;
  logic [3:0] o_valid;
  logic [3:0] o_ready;
  logic       proto_err;
`ifdef DEMUX4_CNT_EN
  logic [15:0] cnt0, cnt1, cnt2, cnt3;
`endif

  int checks   = 0;
  int failures = 0;

  demux4_reg #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .sel       (sel),
    .o0        (o0),
    .o1        (o1),
    .o2        (o2),
    .o3        (o3),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .proto_err (proto_err)
`ifdef DEMUX4_CNT_EN
    ,
    .cnt0      (cnt0),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: four mailboxes, a sticky error and delivery tallies.
  logic [7:0]  m_data [4];
  logic        m_full [4];
  logic        m_err;
  logic [15:0] m_cnt  [4];
  logic        m_was_stalled;
  logic [7:0]  m_last_din;
  logic [1:0]  m_last_sel;

  function automatic logic model_ready();
    return !m_full[sel] || o_ready[sel];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_data[k] = 8'h00;
        m_full[k] = 1'b0;
        m_cnt[k]  = 16'h0000;
      end
      m_err         = 1'b0;
      m_was_stalled = 1'b0;
      m_last_din    = 8'h00;
      m_last_sel    = 2'd0;
    end else begin
      automatic logic take = din_valid && model_ready();
      if (m_was_stalled && (!din_valid || sel != m_last_sel || din != m_last_din))
        m_err = 1'b1;
      m_was_stalled = din_valid && !model_ready();
      m_last_din    = din;
      m_last_sel    = sel;
      for (int k = 0; k < 4; k++) begin
        if (m_full[k] && o_ready[k]) begin
          m_full[k] = 1'b0;
          m_cnt[k]  = m_cnt[k] + 16'd1;
        end
      end
      if (take) begin
        m_data[sel] = din;
        m_full[sel] = 1'b1;
      end
    end
  end

  // Compare DUT against the model every cycle, midway between edges.
  always @(negedge clk) begin
    automatic logic [3:0] mv = {m_full[3], m_full[2], m_full[1], m_full[0]};
    check("cmp_din_ready", 32'(din_ready), 32'(model_ready()));
    check("cmp_o_valid", 32'(o_valid), 32'(mv));
    check("cmp_o0", 32'(o0), 32'(m_data[0]));
    check("cmp_o1", 32'(o1), 32'(m_data[1]));
    check("cmp_o2", 32'(o2), 32'(m_data[2]));
    check("cmp_o3", 32'(o3), 32'(m_data[3]));
    check("cmp_proto_err", 32'(proto_err), 32'(m_err));
`ifdef DEMUX4_CNT_EN
    check("cmp_cnt0", 32'(cnt0), 32'(m_cnt[0]));
    check("cmp_cnt1", 32'(cnt1), 32'(m_cnt[1]));
    check("cmp_cnt2", 32'(cnt2), 32'(m_cnt[2]));
    check("cmp_cnt3", 32'(cnt3), 32'(m_cnt[3]));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [7:0] d);
    sel = s; din = d; din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; din = 8'h00; din_valid = 1'b0; sel = 2'd0; o_ready = 4'b0000;
    #1;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("reset_o_valid", 32'(o_valid), 32'h0);
    check("reset_proto_err", 32'(proto_err), 32'h0);
    check("reset_din_ready", 32'(din_ready), 32'h1);
    check("reset_o2", 32'(o2), 32'h0);

    // Single word to slot 2, immediately consumed.
    o_ready = 4'b1111;
    send(2'd2, 8'hA5);
    check("basic_o2", 32'(o2), 32'hA5);
    check("basic_o_valid", 32'(o_valid), 32'b0100);
    tick();
    check("basic_drained", 32'(o_valid), 32'b0000);
    check("basic_o2_kept", 32'(o2), 32'hA5);

    // Backpressure on slot 1, then pass-through release.
    o_ready = 4'b0000;
    sel = 2'd1; din = 8'h11; din_valid = 1'b1;
    tick();
    din = 8'h22; #1;
    check("bp_o1_first", 32'(o1), 32'h11);
    check("bp_ready_low", 32'(din_ready), 32'h0);
    tick();
    check("bp_held_o1", 32'(o1), 32'h11);
    check("bp_held_ready", 32'(din_ready), 32'h0);
    o_ready = 4'b0010; #1;
    check("bp_passthru_ready", 32'(din_ready), 32'h1);
    tick();
    din_valid = 1'b0;
    check("bp_o1_second", 32'(o1), 32'h22);
    check("bp_o_valid", 32'(o_valid), 32'b0010);
    check("bp_no_err", 32'(proto_err), 32'h0);
    o_ready = 4'b1111;
    tick();

    // Slot 3 stalled while slot 0 streams.
    o_ready = 4'b0000;
    send(2'd3, 8'h33);
    o_ready = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      sel = 2'd0; din = 8'(8'h40 + i); din_valid = 1'b1;
      tick();
      check("stream_o0", 32'(o0), 32'(8'h40 + i));
      check("stream_o3", 32'(o3), 32'h33);
      check("stream_o_valid", 32'(o_valid), 32'b1001);
    end
    din_valid = 1'b0;
    tick();
    check("stream_end_valid", 32'(o_valid), 32'b1000);
    o_ready = 4'b1111;
    tick();

    // Protocol violation: sel changes while an offer is stalled.
    o_ready = 4'b0000;
    send(2'd1, 8'h55);
    sel = 2'd1; din = 8'h66; din_valid = 1'b1;
    tick();
    check("perr_before", 32'(proto_err), 32'h0);
    sel = 2'd2;
    tick();
    din_valid = 1'b0;
    check("perr_set", 32'(proto_err), 32'h1);
    tick(); tick();
    check("perr_sticky", 32'(proto_err), 32'h1);

    // Fill to 4'b1011 then asynchronous reset.
    o_ready = 4'b1111;
    tick();
    o_ready = 4'b0000;
    send(2'd0, 8'h70);
    send(2'd1, 8'h71);
    send(2'd3, 8'h73);
    check("prerst_o_valid", 32'(o_valid), 32'b1011);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_o_valid", 32'(o_valid), 32'h0);
    check("arst_proto_err", 32'(proto_err), 32'h0);
    check("arst_o0", 32'(o0), 32'h0);
    check("arst_o3", 32'(o3), 32'h0);
    check("arst_din_ready", 32'(din_ready), 32'h1);
    sel = 2'd2; din = 8'h99; din_valid = 1'b1;
    tick();
    check("rst_no_accept", 32'(o_valid), 32'h0);
    din_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();

    // Mixed traffic from a fixed table-like pattern; model does the checking.
    for (int i = 0; i < 64; i++) begin
      din       = 8'(i * 7);
      sel       = 2'(i % 4);
      din_valid = (i % 3) != 0;
      o_ready   = 4'((i * 5) % 16);
      tick();
    end
    din_valid = 1'b0;
    o_ready   = 4'b1111;
    tick(); tick();
    check("mix_drained", 32'(o_valid), 32'h0);

`ifdef DEMUX4_CNT_EN
    rst_n = 1'b0; #1;
    check("cnt_reset", 32'(cnt0), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    o_ready = 4'b1111; sel = 2'd0; din_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      din = 8'(i);
      tick();
    end
    din_valid = 1'b0;
    tick();
    check("cnt0_full", 32'(cnt0), 32'hFFFF);
    send(2'd0, 8'hEE);
    tick();
    check("cnt0_wrap", 32'(cnt0), 32'h0);
    check("cnt1_zero", 32'(cnt1), 32'h0);
    check("cnt2_zero", 32'(cnt2), 32'h0);
    check("cnt3_zero", 32'(cnt3), 32'h0);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux4_reg.md
DEMUX4_REG -- requirements
Module: demux4_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of every data port.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port din  input  WIDTH  input data word.
REQ-005 SHALL have port din_valid  input  1  input word present.
REQ-006 SHALL have port din_ready  output  1  input word accepted this cycle when high with din_valid.
REQ-007 SHALL have port sel  input  2  destination index 0..3; sampled with din.
REQ-008 SHALL have ports o0, o1, o2, o3  output  WIDTH  per-destination data.
REQ-009 SHALL have port o_valid  output  4  bit k: ok holds a word.
REQ-010 SHALL have port o_ready  input  4  bit k: destination k consumes ok this cycle.
REQ-011 SHALL have port proto_err  output  1  sticky input-protocol violation flag.

Function
REQ-012 SHALL route each accepted din to the one-entry slot selected by sel; other slots unchanged.
REQ-013 SHALL accept (din_valid && din_ready) with latency 1: word appears on o<sel> with o_valid[sel]=1 the next cycle.
REQ-014 SHALL drive din_ready = !o_valid[sel] || o_ready[sel], combinationally from the current sel (pass-through when slot drains the same cycle).
REQ-015 SHALL hold o<k> and o_valid[k] stable while o_valid[k] && !o_ready[k].
REQ-016 SHALL clear o_valid[k] after o_valid[k] && o_ready[k] unless a new word for k is accepted the same cycle, in which case o_valid[k] stays 1 and o<k> takes the new word.
REQ-017 SHALL allow slots j != sel to drain in the same cycle as an accept to sel; all four slots drain independently.
REQ-018 SHALL ignore o_ready[k] when o_valid[k]=0.
REQ-019 SHALL set proto_err when, in a cycle following din_valid && !din_ready, din_valid drops or sel or din changes; proto_err stays 1 until reset.
REQ-020 SHALL keep o<k> unchanged when slot k is empty (no data zeroing on drain).

Reset
REQ-021 SHALL on rst_n low immediately force o_valid=4'b0000, o0..o3=0, proto_err=0, counters=0; din_ready then follows REQ-014 (=1).
REQ-022 SHALL discard in-flight slot contents on reset mid-operation; no word accepted while rst_n low.

Configuration
REQ-023 SHALL, with DEMUX4_CNT_EN defined, add output cnt0..cnt3 (16 bits each), counting words delivered per destination (o_valid&&o_ready), wrapping 16'hFFFF -> 0.
REQ-024 SHALL, without DEMUX4_CNT_EN, omit cnt ports and counter logic entirely; all other behaviour identical.

Structure
REQ-025 SHALL place N_OUT=4, SEL_W=2, CNT_W=16 in shared package demux4_pkg.
REQ-026 SHALL implement each destination as one instance of sub-module demux_slot (one-entry register with load/drain/valid), four instances total.

Verification
REQ-027 SHALL test: reset, then din=8'hA5, sel=2, valid 1 cycle, o_ready=4'b1111 -> next cycle o2=8'hA5, o_valid=4'b0100, then 4'b0000.
REQ-028 SHALL test: o_ready=0, send 8'h11 sel=1 then 8'h22 sel=1 -> second held, din_ready=0, o1=8'h11; raise o_ready[1] -> same cycle din_ready=1, next cycle o1=8'h22.
REQ-029 SHALL test: slot 3 full/stalled, stream words to sel=0 with o_ready[0]=1 -> one word per cycle on o0, o3 unchanged.
REQ-030 SHALL test: stall on sel=1, change sel to 2 while din_valid held -> proto_err=1 next cycle and stays 1.
REQ-031 SHALL test: rst_n low while o_valid=4'b1011 -> o_valid=0 and proto_err=0 without a clock edge.
REQ-032 SHALL test, with DEMUX4_CNT_EN: preload 65535 deliveries to sel=0 then one more -> cnt0 wraps to 0, cnt1..cnt3=0.
